uplink_stream_arbiter: RTL and testbench
========================================

# uplink_stream_arbiter

Merges the microphone, BME environmental-sensor and RGB-sensor Avalon-ST streams onto one 64-bit tagged uplink stream that feeds the RJ45 serializer. The source streams have no backpressure, so the block buffers each one. It schedules them with microphone priority and a starvation guard, and it reports dropped beats. It sits between the front-end sensor components and the serial link transmitter in the CPLD system.

## Interface
Parameters:
- MIC_FIFO_DEPTH, 8, microphone FIFO entries; power of two, ≥2
- STARVE_LIMIT, 16, maximum consecutive mic grants while a sensor beat is pending; range 1..255

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- mic_input_data  in  32  mic sample
- mic_input_channel  in  5  mic channel
- mic_input_error  in  2  mic error
- mic_input_valid  in  1  mic beat strobe; no ready signal
- bme_input_data  in  64  BME record
- bme_input_error  in  2  BME error
- bme_input_valid  in  1  BME strobe
- rgb_input_data  in  16  RGB record
- rgb_input_error  in  2  RGB error
- rgb_input_valid  in  1  RGB strobe
- uplink_data  out  64  payload; narrower payloads are zero-extended in the LSBs
- uplink_source  out  2  source tag: 0 = mic, 1 = BME, 2 = RGB
- uplink_channel  out  5  mic channel; 0 for sensor beats
- uplink_error  out  2  error, passed through unchanged
- uplink_valid  out  1  beat valid
- uplink_ready  in  1  sink ready
- drop_flags  out  3  sticky overflow flags {rgb, bme, mic}
- drop_clear  in  1  clears drop_flags

## Operation
- Mic beats go into a FIFO of depth MIC_FIFO_DEPTH. BME and RGB beats each go into a one-entry holding register.
- A push to a full buffer drops the new beat. The old contents are kept and the source's drop flag is set.
- Simultaneous push and pop on a full buffer: the push is accepted.
- Output register FSM has two states:
  - EMPTY: uplink_valid = 0.
  - LOADED: uplink_valid = 1.
- A grant occurs when the FSM is in EMPTY, or in LOADED with uplink_ready = 1. When any buffer is non-empty, the granted beat loads into the register and the FSM goes to (or stays in) LOADED. Otherwise the FSM goes to EMPTY.
- In LOADED with uplink_ready = 0, all uplink outputs hold stable.
- Grant priority: mic > BME > RGB.
- Starvation guard:
  - starve_cnt (8-bit) increments on each mic grant made while BME or RGB is pending.
  - starve_cnt clears on any sensor grant, and whenever no sensor is pending.
  - When starve_cnt == STARVE_LIMIT, the next grant goes to the highest-priority pending sensor, even if mic is pending.
- drop_flags: set has priority over drop_clear in the same cycle.

## Timing
- Reset values: uplink_valid 0; uplink_data, uplink_source, uplink_channel, uplink_error 0; drop_flags 0; FSM EMPTY; FIFO and holding registers empty; starve_cnt 0.
- Reset mid-operation discards all buffered beats. Drop flags are not set by the reset.
- Latency: an input beat arriving when its buffer and the FSM are both empty appears on uplink_valid in the next cycle (1 cycle). A beat is not bypassed into the output in the same cycle it arrives.
- Throughput: one beat per cycle while uplink_ready = 1.
- FIFO pointers are log2(MIC_FIFO_DEPTH) bits plus one wrap bit. full and empty are decided from the wrap bit, and pointers wrap without a gap.

## Configuration
- UPLINK_ARB_STATS_EN defined: adds three outputs, mic_drop_count, bme_drop_count and rgb_drop_count, each 16-bit.
  - Each counter increments once per dropped beat and saturates at 0xFFFF.
  - drop_clear and reset clear the counters.
- Not defined: the counters and these ports do not exist. drop_flags behaviour is unchanged.

## Structure
- Package uplink_arb_pkg holds:
  - source-tag enum SRC_MIC/SRC_BME/SRC_RGB
  - width constants: UPLINK_W = 64, MIC_W = 32, MIC_CH_W = 5, ERR_W = 2
  - FSM state enum
- Sub-module uplink_mic_fifo: a synchronous FIFO with a full/empty flag and simultaneous push/pop support. The sensor holding registers stay inline in the top module.

## Test plan
- Reset, then a single mic beat 0xDEADBEEF on channel 3 → one cycle later uplink_data = 0x00000000DEADBEEF, uplink_source = 0, uplink_channel = 3, uplink_valid = 1.
- uplink_ready = 0; push 9 mic beats with depth 8 → the ninth beat is dropped and drop_flags = 3'b001. After drop_clear, drop_flags = 0. With the macro defined, mic_drop_count = 1.
- Continuous mic input with a BME beat held pending, STARVE_LIMIT = 4 → exactly 4 mic beats are output, then the BME beat, then mic output resumes.
- BME and RGB beats in the same cycle with no mic traffic → BME is output first (source 1), then RGB (source 2, data zero-extended).
- A second RGB beat arrives on the same cycle the first RGB beat is granted → no drop, and both beats are output in order.
- Assert reset while LOADED with ready = 0 and the FIFO holding 5 entries → next cycle uplink_valid = 0, buffers empty, drop_flags unchanged at 0.

Source files
------------

// File: rtl/uplink_arb_pkg.sv
// rtl/uplink_arb_pkg.sv - shared tags, widths and FSM states for the uplink stream arbiter
package uplink_arb_pkg;

   localparam int UPLINK_W = 64;
   localparam int MIC_W    = 32;
   localparam int MIC_CH_W = 5;
   localparam int ERR_W    = 2;
   localparam int BME_W    = 64;
   localparam int RGB_W    = 16;
   localparam int MIC_WORD_W = ERR_W + MIC_CH_W + MIC_W;

   typedef enum logic [1:0] {
      SRC_MIC = 2'd0,
      SRC_BME = 2'd1,
      SRC_RGB = 2'd2
   } src_e;

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_LOADED = 1'b1
   } state_e;

   // Clear first, then count the drop, so a drop coinciding with a clear is still recorded.
   function automatic logic [15:0] drop_cnt_next(input logic [15:0] cnt, input logic clr,
                                                 input logic drp);
      logic [15:0] base;
      base = clr ? 16'h0000 : cnt;
      return (drp && base != 16'hFFFF) ? base + 16'h0001 : base;
   endfunction

endpackage

// File: rtl/uplink_mic_fifo.sv
// rtl/uplink_mic_fifo.sv - synchronous microphone FIFO; a push to a full FIFO is dropped
// unless a pop happens in the same cycle.
module uplink_mic_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 39
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         push_ok;
   logic         pop_ok;

   // Equal index with differing wrap bits means the writer is a full lap ahead.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && !push_ok;

   assign pop_data = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uplink_stream_arbiter.sv
// rtl/uplink_stream_arbiter.sv - merges mic/BME/RGB streams onto one tagged 64-bit uplink.
// UPLINK_ARB_STATS_EN adds saturating per-source drop counters.
module uplink_stream_arbiter
   import uplink_arb_pkg::*;
#(
   parameter int MIC_FIFO_DEPTH = 8,
   parameter int STARVE_LIMIT   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [MIC_W-1:0]    mic_input_data,
   input  logic [MIC_CH_W-1:0] mic_input_channel,
   input  logic [ERR_W-1:0]    mic_input_error,
   input  logic                mic_input_valid,
   input  logic [BME_W-1:0]    bme_input_data,
   input  logic [ERR_W-1:0]    bme_input_error,
   input  logic                bme_input_valid,
   input  logic [RGB_W-1:0]    rgb_input_data,
   input  logic [ERR_W-1:0]    rgb_input_error,
   input  logic                rgb_input_valid,
   output logic [UPLINK_W-1:0] uplink_data,
   output logic [1:0]          uplink_source,
   output logic [MIC_CH_W-1:0] uplink_channel,
   output logic [ERR_W-1:0]    uplink_error,
   output logic                uplink_valid,
   input  logic                uplink_ready,
`ifdef UPLINK_ARB_STATS_EN
   output logic [15:0]         mic_drop_count,
   output logic [15:0]         bme_drop_count,
   output logic [15:0]         rgb_drop_count,
`endif
   output logic [2:0]          drop_flags,
   input  logic                drop_clear
);

   localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

   state_e                state_q, state_d;
   logic [UPLINK_W-1:0]   data_q, data_d;
   src_e                  src_q, src_d;
   logic [MIC_CH_W-1:0]   ch_q, ch_d;
   logic [ERR_W-1:0]      err_q, err_d;

   logic                  bme_full_q, bme_full_d;
   logic [BME_W-1:0]      bme_data_q, bme_data_d;
   logic [ERR_W-1:0]      bme_err_q, bme_err_d;
   logic                  rgb_full_q, rgb_full_d;
   logic [RGB_W-1:0]      rgb_data_q, rgb_data_d;
   logic [ERR_W-1:0]      rgb_err_q, rgb_err_d;

   logic [7:0]            starve_q, starve_d;
   logic [2:0]            drop_q, drop_d;

   logic [MIC_WORD_W-1:0] mic_word;
   logic                  mic_full;
   logic                  mic_empty;
   logic                  mic_drop;
   logic                  bme_drop;
   logic                  rgb_drop;

   logic                  grant;
   logic                  sensor_pend;
   logic                  force_sensor;
   logic                  sel_mic;
   logic                  sel_bme;
   logic                  sel_rgb;

   uplink_mic_fifo #(
      .DEPTH (MIC_FIFO_DEPTH),
      .W     (MIC_WORD_W)
   ) u_mic_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (mic_input_valid),
      .push_data ({mic_input_error, mic_input_channel, mic_input_data}),
      .pop       (sel_mic),
      .pop_data  (mic_word),
      .full      (mic_full),
      .empty     (mic_empty),
      .drop      (mic_drop)
   );

   // Only buffered beats compete; an arriving beat is never bypassed to the output.
   assign grant        = (state_q == ST_EMPTY) || uplink_ready;
   assign sensor_pend  = bme_full_q || rgb_full_q;
   assign force_sensor = sensor_pend && (starve_q == STARVE_LIM8);
   assign sel_mic      = grant && !mic_empty && !force_sensor;
   assign sel_bme      = grant && bme_full_q && !sel_mic;
   assign sel_rgb      = grant && rgb_full_q && !sel_mic && !bme_full_q;

   assign bme_drop = bme_input_valid && bme_full_q && !sel_bme;
   assign rgb_drop = rgb_input_valid && rgb_full_q && !sel_rgb;

   always_comb begin
      bme_full_d = bme_full_q;
      bme_data_d = bme_data_q;
      bme_err_d  = bme_err_q;
      rgb_full_d = rgb_full_q;
      rgb_data_d = rgb_data_q;
      rgb_err_d  = rgb_err_q;
      if (sel_bme) bme_full_d = 1'b0;
      if (bme_input_valid && !bme_drop) begin
         bme_full_d = 1'b1;
         bme_data_d = bme_input_data;
         bme_err_d  = bme_input_error;
      end
      if (sel_rgb) rgb_full_d = 1'b0;
      if (rgb_input_valid && !rgb_drop) begin
         rgb_full_d = 1'b1;
         rgb_data_d = rgb_input_data;
         rgb_err_d  = rgb_input_error;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      ch_d    = ch_q;
      err_d   = err_q;
      if (grant) begin
         state_d = ST_LOADED;
         if (sel_mic) begin
            data_d = UPLINK_W'(mic_word[MIC_W-1:0]);
            src_d  = SRC_MIC;
            ch_d   = mic_word[MIC_W +: MIC_CH_W];
            err_d  = mic_word[MIC_W+MIC_CH_W +: ERR_W];
         end else if (sel_bme) begin
            data_d = UPLINK_W'(bme_data_q);
            src_d  = SRC_BME;
            ch_d   = '0;
            err_d  = bme_err_q;
         end else if (sel_rgb) begin
            data_d = UPLINK_W'(rgb_data_q);
            src_d  = SRC_RGB;
            ch_d   = '0;
            err_d  = rgb_err_q;
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!sensor_pend || sel_bme || sel_rgb) starve_d = 8'd0;
      else if (sel_mic)                       starve_d = starve_q + 8'd1;
   end

   assign drop_d = (drop_q & ~{3{drop_clear}}) | {rgb_drop, bme_drop, mic_drop};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         data_q     <= '0;
         src_q      <= SRC_MIC;
         ch_q       <= '0;
         err_q      <= '0;
         bme_full_q <= 1'b0;
         bme_data_q <= '0;
         bme_err_q  <= '0;
         rgb_full_q <= 1'b0;
         rgb_data_q <= '0;
         rgb_err_q  <= '0;
         starve_q   <= 8'd0;
         drop_q     <= 3'b000;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         src_q      <= src_d;
         ch_q       <= ch_d;
         err_q      <= err_d;
         bme_full_q <= bme_full_d;
         bme_data_q <= bme_data_d;
         bme_err_q  <= bme_err_d;
         rgb_full_q <= rgb_full_d;
         rgb_data_q <= rgb_data_d;
         rgb_err_q  <= rgb_err_d;
         starve_q   <= starve_d;
         drop_q     <= drop_d;
      end
   end

`ifdef UPLINK_ARB_STATS_EN
   logic [15:0] mic_cnt_q, bme_cnt_q, rgb_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mic_cnt_q <= 16'h0000;
         bme_cnt_q <= 16'h0000;
         rgb_cnt_q <= 16'h0000;
      end else begin
         mic_cnt_q <= drop_cnt_next(mic_cnt_q, drop_clear, mic_drop);
         bme_cnt_q <= drop_cnt_next(bme_cnt_q, drop_clear, bme_drop);
         rgb_cnt_q <= drop_cnt_next(rgb_cnt_q, drop_clear, rgb_drop);
      end
   end

   assign mic_drop_count = mic_cnt_q;
   assign bme_drop_count = bme_cnt_q;
   assign rgb_drop_count = rgb_cnt_q;
`endif

   assign uplink_valid   = (state_q == ST_LOADED);
   assign uplink_data    = data_q;
   assign uplink_source  = src_q;
   assign uplink_channel = ch_q;
   assign uplink_error   = err_q;
   assign drop_flags     = drop_q;

endmodule

// File: tb/tb_uplink_stream_arbiter.sv
// tb/tb_uplink_stream_arbiter.sv - directed and randomized checks against a queue-based model
module tb_uplink_stream_arbiter;

   localparam int DEPTH = 8;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mic_input_data;
   logic [4:0]  mic_input_channel;
   logic [1:0]  mic_input_error;
   logic        mic_input_valid;
   logic [63:0] bme_input_data;
   logic [1:0]  bme_input_error;
   logic        bme_input_valid;
   logic [15:0] rgb_input_data;
   logic [1:0]  rgb_input_error;
   logic        rgb_input_valid;
   logic [63:0] uplink_data;
   logic [1:0]  uplink_source;
   logic [4:0]  uplink_channel;
   logic [1:0]  uplink_error;
   logic        uplink_valid;
   logic        uplink_ready;
   logic [2:0]  drop_flags;
   logic        drop_clear;
`ifdef UPLINK_ARB_STATS_EN
   logic [15:0] mic_drop_count, bme_drop_count, rgb_drop_count;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [38:0] m_mic[$];
   logic        m_bme_full, m_rgb_full;
   logic [63:0] m_bme_data;
   logic [15:0] m_rgb_data;
   logic [1:0]  m_bme_err, m_rgb_err;
   logic        m_valid;
   logic [63:0] m_data;
   logic [1:0]  m_src;
   logic [4:0]  m_ch;
   logic [1:0]  m_err;
   int          m_starve;
   logic [2:0]  m_flags;
   int          m_cnt[3];

   uplink_stream_arbiter #(
      .MIC_FIFO_DEPTH (DEPTH),
      .STARVE_LIMIT   (LIMIT)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .mic_input_data    (mic_input_data),
      .mic_input_channel (mic_input_channel),
      .mic_input_error   (mic_input_error),
      .mic_input_valid   (mic_input_valid),
      .bme_input_data    (bme_input_data),
      .bme_input_error   (bme_input_error),
      .bme_input_valid   (bme_input_valid),
      .rgb_input_data    (rgb_input_data),
      .rgb_input_error   (rgb_input_error),
      .rgb_input_valid   (rgb_input_valid),
      .uplink_data       (uplink_data),
      .uplink_source     (uplink_source),
      .uplink_channel    (uplink_channel),
      .uplink_error      (uplink_error),
      .uplink_valid      (uplink_valid),
      .uplink_ready      (uplink_ready),
`ifdef UPLINK_ARB_STATS_EN
      .mic_drop_count    (mic_drop_count),
      .bme_drop_count    (bme_drop_count),
      .rgb_drop_count    (rgb_drop_count),
`endif
      .drop_flags        (drop_flags),
      .drop_clear        (drop_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mic.delete();
      m_bme_full = 0; m_rgb_full = 0;
      m_bme_data = '0; m_rgb_data = '0; m_bme_err = '0; m_rgb_err = '0;
      m_valid = 0; m_data = '0; m_src = 0; m_ch = 0; m_err = 0;
      m_starve = 0; m_flags = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   // One clock edge of the arbitration rules, applied to the inputs held across that edge.
   task automatic model_step();
      logic        grant, pend;
      int          src;
      logic [38:0] w;
      logic [2:0]  drp;
      if (reset) begin
         model_reset();
         return;
      end
      grant = !m_valid || uplink_ready;
      pend  = m_bme_full || m_rgb_full;
      src   = -1;
      if (grant) begin
         if (pend && m_starve == LIMIT) src = m_bme_full ? 1 : 2;
         else if (m_mic.size() > 0)     src = 0;
         else if (m_bme_full)           src = 1;
         else if (m_rgb_full)           src = 2;
      end
      if (!pend || src == 1 || src == 2) m_starve = 0;
      else if (src == 0)                 m_starve++;
      if (grant) m_valid = (src >= 0);
      if (src == 0) begin
         w = m_mic.pop_front();
         m_data = {32'h0, w[31:0]}; m_ch = w[36:32]; m_err = w[38:37]; m_src = 0;
      end else if (src == 1) begin
         m_data = m_bme_data; m_ch = 0; m_err = m_bme_err; m_src = 1; m_bme_full = 0;
      end else if (src == 2) begin
         m_data = {48'h0, m_rgb_data}; m_ch = 0; m_err = m_rgb_err; m_src = 2; m_rgb_full = 0;
      end
      drp = 0;
      if (mic_input_valid) begin
         if (m_mic.size() < DEPTH) m_mic.push_back({mic_input_error, mic_input_channel, mic_input_data});
         else drp[0] = 1;
      end
      if (bme_input_valid) begin
         if (m_bme_full) drp[1] = 1;
         else begin m_bme_full = 1; m_bme_data = bme_input_data; m_bme_err = bme_input_error; end
      end
      if (rgb_input_valid) begin
         if (m_rgb_full) drp[2] = 1;
         else begin m_rgb_full = 1; m_rgb_data = rgb_input_data; m_rgb_err = rgb_input_error; end
      end
      m_flags = (drop_clear ? 3'b000 : m_flags) | drp;
      for (int i = 0; i < 3; i++) begin
         if (drop_clear) m_cnt[i] = 0;
         if (drp[i] && m_cnt[i] < 65535) m_cnt[i]++;
      end
   endtask

   task automatic check_all();
      chk("valid", 64'(uplink_valid), 64'(m_valid));
      if (m_valid) begin
         chk("data", uplink_data, m_data);
         chk("source", 64'(uplink_source), 64'(m_src));
         chk("channel", 64'(uplink_channel), 64'(m_ch));
         chk("error", 64'(uplink_error), 64'(m_err));
      end
      chk("drop_flags", 64'(drop_flags), 64'(m_flags));
`ifdef UPLINK_ARB_STATS_EN
      chk("mic_drop_count", 64'(mic_drop_count), 64'(m_cnt[0]));
      chk("bme_drop_count", 64'(bme_drop_count), 64'(m_cnt[1]));
      chk("rgb_drop_count", 64'(rgb_drop_count), 64'(m_cnt[2]));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      mic_input_valid = 0; bme_input_valid = 0; rgb_input_valid = 0; drop_clear = 0;
   endtask

   initial begin
      reset = 1; uplink_ready = 0; idle_inputs();
      mic_input_data = 0; mic_input_channel = 0; mic_input_error = 0;
      bme_input_data = 0; bme_input_error = 0; rgb_input_data = 0; rgb_input_error = 0;
      model_reset();
      cycle(); cycle();
      chk("rst_valid", 64'(uplink_valid), 64'd0);
      chk("rst_data", uplink_data, 64'd0);
      chk("rst_flags", 64'(drop_flags), 64'd0);
      reset = 0;

      // Single mic beat: one cycle of latency, held while ready is low.
      uplink_ready = 1;
      mic_input_valid = 1; mic_input_data = 32'hDEADBEEF; mic_input_channel = 5'd3;
      cycle();
      chk("lat_not_bypassed", 64'(uplink_valid), 64'd0);
      mic_input_valid = 0; uplink_ready = 0;
      cycle();
      chk("lat_valid", 64'(uplink_valid), 64'd1);
      chk("lat_data", uplink_data, 64'h00000000DEADBEEF);
      chk("lat_source", 64'(uplink_source), 64'd0);
      chk("lat_channel", 64'(uplink_channel), 64'd3);

      // Nine pushes into a full-capacity 8-entry FIFO: the ninth is dropped.
      for (int i = 0; i < 9; i++) begin
         mic_input_valid = 1; mic_input_data = 32'h100 + i; mic_input_channel = 5'(i);
         cycle();
      end
      mic_input_valid = 0;
      chk("ovf_flags", 64'(drop_flags), 64'd1);
`ifdef UPLINK_ARB_STATS_EN
      chk("ovf_count", 64'(mic_drop_count), 64'd1);
`endif
      drop_clear = 1; cycle(); drop_clear = 0;
      chk("clr_flags", 64'(drop_flags), 64'd0);
      chk("hold_data", uplink_data, 64'h00000000DEADBEEF);

      // Drain three beats so five remain, then reset while loaded and stalled.
      uplink_ready = 1;
      for (int i = 0; i < 3; i++) cycle();
      chk("pre_rst_data", uplink_data, 64'h102);
      uplink_ready = 0; reset = 1;
      cycle();
      reset = 0;
      chk("midrst_valid", 64'(uplink_valid), 64'd0);
      chk("midrst_flags", 64'(drop_flags), 64'd0);
      uplink_ready = 1;
      cycle(); cycle();
      chk("midrst_empty", 64'(uplink_valid), 64'd0);

      // Starvation guard: LIMIT mic beats, then the pending BME beat, then mic again.
      for (int i = 0; i < 3; i++) begin
         mic_input_valid = 1; mic_input_data = $urandom; cycle();
      end
      bme_input_valid = 1; bme_input_data = 64'hB0B0_0000_CAFE_0001; cycle();
      bme_input_valid = 0;
      for (int j = 0; j < 6; j++) begin
         mic_input_data = $urandom; cycle();
         chk("starve_src", 64'(uplink_source), (j == 4) ? 64'd1 : 64'd0);
      end
      mic_input_valid = 0;
      for (int i = 0; i < 6; i++) cycle();

      // Simultaneous BME and RGB: BME first, RGB zero-extended.
      bme_input_valid = 1; bme_input_data = 64'h1122334455667788;
      rgb_input_valid = 1; rgb_input_data = 16'hA5C3;
      cycle();
      bme_input_valid = 0; rgb_input_valid = 0;
      cycle();
      chk("bme_first_src", 64'(uplink_source), 64'd1);
      chk("bme_first_data", uplink_data, 64'h1122334455667788);
      cycle();
      chk("rgb_second_src", 64'(uplink_source), 64'd2);
      chk("rgb_second_data", uplink_data, 64'h000000000000A5C3);
      cycle();

      // Second RGB beat arrives as the first is granted: no drop.
      rgb_input_valid = 1; rgb_input_data = 16'h1111; cycle();
      rgb_input_data = 16'h2222; cycle();
      chk("rgb_a", uplink_data, 64'h1111);
      rgb_input_valid = 0; cycle();
      chk("rgb_b", uplink_data, 64'h2222);
      chk("rgb_nodrop", 64'(drop_flags), 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         reset             = ($urandom_range(0, 99) == 0);
         drop_clear        = ($urandom_range(0, 15) == 0);
         uplink_ready      = ($urandom_range(0, 9) < 6);
         mic_input_valid   = ($urandom_range(0, 9) < 6);
         mic_input_data    = $urandom;
         mic_input_channel = 5'($urandom_range(0, 31));
         mic_input_error   = 2'($urandom_range(0, 3));
         bme_input_valid   = ($urandom_range(0, 9) < 2);
         bme_input_data    = {$urandom, $urandom};
         bme_input_error   = 2'($urandom_range(0, 3));
         rgb_input_valid   = ($urandom_range(0, 9) < 2);
         rgb_input_data    = 16'($urandom);
         rgb_input_error   = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
